// File: rtl/register_file_sb_if.sv
// Register file / scoreboard bus: packed read ports, one write port, one reservation port.
interface register_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD*ADDR_W-1:0] rsel;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic [ADDR_W-1:0]        wsel;
    logic [DATA_W-1:0]        wdata;
    logic                     wen;
    logic [ADDR_W-1:0]        rsv_sel;
    logic                     rsv_en;
    logic                     rsv_ok;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rsel, wsel, wdata, wen, rsv_sel, rsv_en,
        input  rdata, rbusy, rsv_ok, busy_cnt
    );
    modport slave (
        input  rsel, wsel, wdata, wen, rsv_sel, rsv_en,
        output rdata, rbusy, rsv_ok, busy_cnt
    );
endinterface

// File: rtl/register_file_sb.sv
// Register file with per-register busy scoreboard and NUM_RD combinational read ports.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module rf_rd_lane #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic [ADDR_W-1:0]                sel,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              busy,
    input  logic                             fwd,
    input  logic [DATA_W-1:0]                wdata,
    output logic [DATA_W-1:0]                rdata,
    output logic                             rbusy
);
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (fwd) begin
            rdata = wdata;
        end else if (sel != '0) begin
            rdata = regs[sel];
            rbusy = busy[sel];
        end
    end
endmodule

module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input logic                clk,
    input logic                rst,
    register_file_sb_if.slave  rf
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(NUM_REGS - 1);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy, busy_n;
    logic [ADDR_W:0]                 cnt;
    logic                            wr_hit, same, rsv_set, rsv_new, wr_clr;
    logic [NUM_RD-1:0][DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]               rbusy;

    // A write to the requested register this cycle counts as a clear, so the
    // reservation is accepted; the set wins and the count nets to no change.
    always_comb begin
        wr_hit    = rf.wen && (rf.wsel != '0);
        same      = wr_hit && (rf.wsel == rf.rsv_sel);
        rf.rsv_ok = rf.rsv_en && ((rf.rsv_sel == '0) || !busy[rf.rsv_sel] || same);
        rsv_set   = rf.rsv_ok && (rf.rsv_sel != '0);
        rsv_new   = rsv_set && !busy[rf.rsv_sel];
        wr_clr    = wr_hit && busy[rf.wsel] && !(rsv_set && same);
        busy_n    = busy;
        if (wr_hit)  busy_n[rf.wsel]    = 1'b0;
        if (rsv_set) busy_n[rf.rsv_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wr_hit) regs[rf.wsel] <= rf.wdata;
            busy <= busy_n;
            if (rsv_new && !wr_clr && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            else if (wr_clr && !rsv_new && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign rf.busy_cnt = cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        logic              fwd;
        assign sel = rf.rsel[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        assign fwd = wr_hit && (rf.wsel == sel);
`else
        assign fwd = 1'b0;
`endif
        rf_rd_lane #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_lane (
            .sel   (sel),
            .regs  (regs),
            .busy  (busy),
            .fwd   (fwd),
            .wdata (rf.wdata),
            .rdata (rdata[k]),
            .rbusy (rbusy[k])
        );
    end

    assign rf.rdata = rdata;
    assign rf.rbusy = rbusy;
endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32: register data width in bits.
REQ-003 Parameter NUM_REGS, default 32: number of registers, power of two and at least 2; ADDR_W = log2(NUM_REGS).
REQ-004 Parameter NUM_RD, default 2: number of independent read ports, 1 to 4.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 rsel  in  NUM_RD*ADDR_W  packed read selects; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-008 rdata  out  NUM_RD*DATA_W  packed read data, same packing as rsel.
REQ-009 rbusy  out  NUM_RD  per-port flag: the selected register has an outstanding reservation.
REQ-010 wsel / wdata / wen  in  ADDR_W / DATA_W / 1  write select, write data and write enable.
REQ-011 rsv_sel / rsv_en  in  ADDR_W / 1  scoreboard reservation request for the destination of an issued instruction.
REQ-012 rsv_ok  out  1  combinational: the reservation request is accepted this cycle.
REQ-013 busy_cnt  out  ADDR_W+1  registered count of currently reserved registers.

Function
REQ-014 Reads SHALL be combinational: rdata[k] = reg[rsel[k]], and rbusy[k] = busy[rsel[k]].
REQ-015 Register 0 SHALL always read 0 with rbusy 0; writes to it and reservations of it are ignored.
REQ-016 When wen=1 and wsel!=0, reg[wsel] SHALL take wdata at the rising edge and busy[wsel] SHALL clear at the same edge.
REQ-017 rsv_ok SHALL be 1 when rsv_en=1 and either rsv_sel=0 or busy[rsv_sel]=0, with a write to the same register in the same cycle counting as a clear; otherwise rsv_ok SHALL be 0.
REQ-018 An accepted reservation with rsv_sel!=0 SHALL set busy[rsv_sel] at the rising edge.
REQ-019 A rejected reservation (rsv_ok=0) SHALL leave all state unchanged; the requester stalls and retries.
REQ-020 If a write and an accepted reservation target the same register in one cycle, the data SHALL be written, busy SHALL end set, and busy_cnt SHALL be unchanged.
REQ-021 busy_cnt SHALL increment by one per accepted reservation of a non-zero register that was not busy.
REQ-022 busy_cnt SHALL decrement by one per write that clears a set busy bit; net change SHALL be computed when both events occur in one cycle.
REQ-023 busy_cnt SHALL never exceed NUM_REGS-1 and SHALL never wrap below 0.
REQ-024 A write to a register that is not busy SHALL update the data only, with no change to busy_cnt.

Reset
REQ-025 While rst=0, all registers SHALL be 0, all busy bits 0 and busy_cnt 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard pending writes and reservations immediately; rdata, rbusy and busy_cnt SHALL read 0 asynchronously.
REQ-027 The first write or reservation SHALL take effect at the first rising edge with rst=1.

Configuration
REQ-028 Macro RF_BYPASS_EN defined: when wen=1, wsel!=0 and wsel=rsel[k], rdata[k] SHALL be wdata and rbusy[k] SHALL be 0 in the same cycle (write-through forwarding).
REQ-029 Macro RF_BYPASS_EN undefined: rdata[k] and rbusy[k] SHALL show the stored value and busy bit until the edge; rsv_ok behaviour is unchanged.

Verification
REQ-030 Reset, then write 0xDEADBEEF to r5 -> after the edge, both ports read 0xDEADBEEF with rbusy=0.
REQ-031 Write 0xFFFFFFFF to r0 and reserve r0 -> rdata=0, rbusy=0, rsv_ok=1, busy_cnt stays 0.
REQ-032 Reserve r10 -> busy_cnt=1 and rbusy=1 on r10; reserve r10 again -> rsv_ok=0; write 0x12345678 to r10 -> busy_cnt=0 and data reads 0x12345678.
REQ-033 r15=0xAAAAAAAA, then in one cycle write 0x1 to r15 while reading r15 -> with RF_BYPASS_EN read 0x1 before the edge; without it read 0xAAAAAAAA before and 0x1 after.
REQ-034 Reserve r3 and r7, then in one cycle write r3 and reserve r3 -> busy_cnt stays 2, r3 stays busy, new data is stored.
REQ-035 Reserve 4 registers, then drop rst between clock edges -> busy_cnt=0 and all rdata=0 at once, with no edge required.
